// File: rtl/majority_pkg.sv
// Shared definitions for the windowed majority voter.
// Provides the FSM state type, the default parameter values, and a helper
// that sizes the per-bit ones-counters and the sample index.
package majority_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_WINDOW = 3;
    localparam int DEF_THRESH = (DEF_WINDOW + 1) / 2;

    // Bits needed to count 0..window without wrapping.
    function automatic int unsigned cnt_width(input int unsigned window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/bit_vote_counter.sv
// One bit lane of the voter: counts ones seen in the current window and
// compares the running count (including the sample being accepted this
// cycle) against the threshold.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr_i     - clear the counter at the next edge (abort or window complete)
//   inc_i     - an accepted sample has a 1 in this lane
//   vote_o    - count including this cycle's sample >= THRESH
module bit_vote_counter
    import majority_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW,
    parameter int THRESH = DEF_THRESH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic vote_o
);

    localparam int unsigned CW = cnt_width(WINDOW);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    // The counter is cleared on the last sample of a window, so it never
    // exceeds WINDOW and the increment cannot wrap.
    assign cnt_inc = cnt_q + CW'(inc_i);
    assign vote_o  = (cnt_inc >= CW'(THRESH));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/majority_voter_window.sv
// Windowed per-bit majority voter.
// Collects WINDOW accepted samples, then presents out_data[i] = 1 when at
// least THRESH of those samples had bit i set. The result is held until the
// consumer takes it; no new samples are accepted meanwhile.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   in_valid/in_ready    - sample handshake, in_data is the sample word
//   abort                - discard the partial window (ignored while holding)
//   out_valid/out_ready  - result handshake, out_data is the vote result
module majority_voter_window
    import majority_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WINDOW = DEF_WINDOW,
    parameter int THRESH = (WINDOW + 1) / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (WIDTH < 1) begin : g_bad_width
        $error("majority_voter_window: WIDTH must be >= 1");
    end
    if (WINDOW < 1) begin : g_bad_window
        $error("majority_voter_window: WINDOW must be >= 1");
    end
    if ((THRESH < 1) || (THRESH > WINDOW)) begin : g_bad_thresh
        $error("majority_voter_window: THRESH must be in 1..WINDOW");
    end

    localparam int unsigned CW = cnt_width(WINDOW);

    state_e           state_q;
    state_e           state_d;
    logic [CW-1:0]    idx_q;
    logic [CW-1:0]    idx_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [WIDTH-1:0] votes;

    logic accept;
    logic last;
    logic clr;

    assign accept = in_valid && in_ready;
    assign last   = (idx_q == CW'(WINDOW - 1));
    // Counters restart on abort in ACCUM or once the window completes.
    assign clr    = ((state_q == ACCUM) && abort) || (accept && last);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        bit_vote_counter #(
            .WINDOW(WINDOW),
            .THRESH(THRESH)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr_i (clr),
            .inc_i (accept && in_data[i]),
            .vote_o(votes[i])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && last) state_d = HOLD;
            HOLD:    if (out_ready)      state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == ACCUM) && !abort;
        out_valid = (state_q == HOLD);
    end

    assign out_data = out_data_q;

    // Sample index and result register
    always_comb begin
        idx_d      = idx_q;
        out_data_d = out_data_q;
        if (clr) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = idx_q + 1'b1;
        end
        if (accept && last) begin
            out_data_d = votes;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            out_data_q <= '0;
        end else begin
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_majority_voter_window.sv
// Bench for majority_voter_window: four instances with different WINDOW /
// THRESH settings, each tracked every cycle by a sample-list reference model.
module tb_majority_voter_window;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [N];
    logic       in_ready  [N];
    logic [7:0] in_data   [N];
    logic       abort     [N];
    logic       out_valid [N];
    logic       out_ready [N];
    logic [7:0] out_data  [N];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          started = 1'b0;

    // Reference model: list of accepted samples, pending result, hold flag.
    int unsigned m_win [N] = '{3, 3, 3, 1};
    int unsigned m_th  [N] = '{2, 1, 3, 1};
    bit          m_hold[N];
    logic [7:0]  m_res [N];
    logic [7:0]  m_buf [N][3];
    int unsigned m_n   [N];

    always #5 clk = ~clk;

    majority_voter_window #(.WIDTH(8), .WINDOW(3), .THRESH(2)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .abort(abort[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]));
    majority_voter_window #(.WIDTH(8), .WINDOW(3), .THRESH(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .abort(abort[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]));
    majority_voter_window #(.WIDTH(8), .WINDOW(3), .THRESH(3)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .abort(abort[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]));
    majority_voter_window #(.WIDTH(8), .WINDOW(1), .THRESH(1)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .abort(abort[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .out_data(out_data[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_vote(input int k);
        logic [7:0]  r;
        int unsigned ones;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int unsigned s = 0; s < m_n[k]; s++) ones += 32'(m_buf[k][s][b]);
            r[b] = (ones >= m_th[k]);
        end
        return r;
    endfunction

    // Compare all instances against the model, away from the clock edge.
    task automatic half_a();
        @(negedge clk);
        if (started) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("d%0d_in_ready", k), 32'(in_ready[k]), 32'(!m_hold[k] && !abort[k]));
                chk($sformatf("d%0d_out_valid", k), 32'(out_valid[k]), 32'(m_hold[k]));
                chk($sformatf("d%0d_out_data", k), 32'(out_data[k]), 32'(m_res[k]));
            end
        end
    endtask

    // Advance the model by the same edge the DUTs see.
    task automatic half_b();
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                m_hold[k] = 1'b0;
                m_res[k]  = '0;
                m_n[k]    = 0;
            end else if (m_hold[k]) begin
                if (out_ready[k]) m_hold[k] = 1'b0;
            end else if (abort[k]) begin
                m_n[k] = 0;
            end else if (in_valid[k]) begin
                m_buf[k][m_n[k]] = in_data[k];
                m_n[k]++;
                if (m_n[k] == m_win[k]) begin
                    m_res[k]  = ref_vote(k);
                    m_n[k]    = 0;
                    m_hold[k] = 1'b1;
                end
            end
        end
        if (rst) started = 1'b1;
        #1;
    endtask

    task automatic cyc();
        half_a();
        half_b();
    endtask

    task automatic idle();
        for (int k = 0; k < N; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            abort[k]     = 1'b0;
            out_ready[k] = 1'b0;
        end
    endtask

    task automatic send0(input logic [7:0] d);
        in_valid[0] = 1'b1;
        in_data[0]  = d;
        cyc();
        in_valid[0] = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // First cycle after reset
        half_a();
        chk("rst_in_ready", 32'(in_ready[0]), 1);
        chk("rst_out_valid", 32'(out_valid[0]), 0);
        chk("rst_out_data", 32'(out_data[0]), 0);
        half_b();

        // Back-to-back window, consumer always ready
        out_ready[0] = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0] = 8'hF0; cyc();
        in_data[0] = 8'hCC; cyc();
        in_data[0] = 8'hAA; cyc();
        in_valid[0] = 1'b0;
        half_a();
        chk("bb_out_valid", 32'(out_valid[0]), 1);
        chk("bb_out_data", 32'(out_data[0]), 32'hE8);
        half_b();
        cyc();

        // Stalled consumer
        out_ready[0] = 1'b0;
        send0(8'hF0); send0(8'hCC); send0(8'hAA);
        for (int i = 0; i < 4; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 8'h33;
            half_a();
            chk("stall_data", 32'(out_data[0]), 32'hE8);
            chk("stall_in_ready", 32'(in_ready[0]), 0);
            half_b();
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        cyc();
        out_ready[0] = 1'b0;
        half_a();
        chk("stall_ready_after", 32'(in_ready[0]), 1);
        half_b();

        // Abort wins over in_valid
        out_ready[0] = 1'b1;
        send0(8'hFF); send0(8'hFF);
        in_valid[0] = 1'b1; in_data[0] = 8'hFF; abort[0] = 1'b1;
        half_a();
        chk("abort_in_ready", 32'(in_ready[0]), 0);
        half_b();
        abort[0] = 1'b0;
        send0(8'h0F); send0(8'h0F); send0(8'hF0);
        half_a();
        chk("abort_out_valid", 32'(out_valid[0]), 1);
        chk("abort_out_data", 32'(out_data[0]), 32'h0F);
        half_b();
        cyc();

        // Reset mid-window, then reset during HOLD
        send0(8'hAB); send0(8'hCD);
        rst = 1'b1; cyc(); rst = 1'b0;
        half_a();
        chk("rst_mid_ready", 32'(in_ready[0]), 1);
        chk("rst_mid_data", 32'(out_data[0]), 0);
        half_b();
        out_ready[0] = 1'b0;
        send0(8'h12); send0(8'h34); send0(8'h56);
        rst = 1'b1; cyc(); rst = 1'b0;
        half_a();
        chk("rst_hold_valid", 32'(out_valid[0]), 0);
        chk("rst_hold_data", 32'(out_data[0]), 0);
        chk("rst_hold_ready", 32'(in_ready[0]), 1);
        half_b();
        out_ready[0] = 1'b1;
        send0(8'h00); send0(8'h01); send0(8'h01);
        half_a();
        chk("rst_after_data", 32'(out_data[0]), 32'h01);
        half_b();
        cyc();

        // THRESH=1 and THRESH=3 instances side by side
        out_ready[1] = 1'b1; out_ready[2] = 1'b1;
        in_valid[1]  = 1'b1; in_valid[2]  = 1'b1;
        in_data[1] = 8'h01; in_data[2] = 8'h07; cyc();
        in_data[1] = 8'h02; in_data[2] = 8'h03; cyc();
        in_data[1] = 8'h04; in_data[2] = 8'h01; cyc();
        in_valid[1] = 1'b0; in_valid[2] = 1'b0;
        half_a();
        chk("th1_data", 32'(out_data[1]), 32'h07);
        chk("th3_data", 32'(out_data[2]), 32'h01);
        half_b();

        // WINDOW=1 streaming
        out_ready[3] = 1'b1;
        in_valid[3]  = 1'b1;
        in_data[3]   = 8'h5A; cyc();
        in_data[3]   = 8'hA5;
        half_a();
        chk("w1_first_valid", 32'(out_valid[3]), 1);
        chk("w1_first_data", 32'(out_data[3]), 32'h5A);
        half_b();
        cyc();
        in_valid[3] = 1'b0;
        half_a();
        chk("w1_second_valid", 32'(out_valid[3]), 1);
        chk("w1_second_data", 32'(out_data[3]), 32'hA5);
        half_b();

        // Randomized traffic on all instances
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(99) == 0);
            for (int k = 0; k < N; k++) begin
                in_valid[k]  = ($urandom_range(9) < 7);
                in_data[k]   = 8'($urandom);
                abort[k]     = ($urandom_range(19) == 0);
                out_ready[k] = ($urandom_range(9) < 6);
            end
            cyc();
        end
        idle();
        rst = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
